// File: rtl/seq_det_pkg.sv
// Shared constants and types for the programmable serial pattern detector.
// Pattern length is bounded by PAT_W_MAX; the fill counter must hold 0..PAT_W_MAX.
package seq_det_pkg;

  localparam int PAT_W_MAX = 32;

  typedef logic [$clog2(PAT_W_MAX+1)-1:0] fill_t;

  localparam logic [2:0] PAT_INIT_DEF = 3'b101;
  localparam logic       OVL_INIT_DEF = 1'b1;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear that takes priority over increment.
// Asynchronous active-low reset.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Holding at all-ones avoids wrapping back to zero after many matches.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/seq_detect_prog.sv
// Run-time programmable serial bit-pattern detector with overlap/non-overlap modes.
// Define SEQ_DET_CNT_EN to build the saturating match counter; otherwise match_cnt is tied to 0.
module seq_detect_prog
  import seq_det_pkg::*;
#(
  parameter int               PAT_W    = 3,
  parameter logic [PAT_W-1:0] PAT_INIT = PAT_W'(PAT_INIT_DEF),
  parameter logic             OVL_INIT = OVL_INIT_DEF,
  parameter int               CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             din,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pat,
  input  logic             cfg_overlap,
  input  logic             cnt_clr,
  output logic             dout,
  output logic [CNT_W-1:0] match_cnt
);

  if (PAT_W < 2 || PAT_W > PAT_W_MAX) begin : g_bad_pat_w
    $error("seq_detect_prog: PAT_W out of range");
  end

  localparam fill_t FILL_FULL = fill_t'(PAT_W);

  logic [PAT_W-1:0] hist_q, hist_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  fill_t            fill_q, fill_d;
  logic             ovl_q, ovl_d;
  logic             dout_q, dout_d;

  logic [PAT_W-1:0] newHist;
  fill_t            newFill;
  logic             hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_q <= '0;
      fill_q <= '0;
      pat_q  <= PAT_INIT;
      ovl_q  <= OVL_INIT;
      dout_q <= 1'b0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      pat_q  <= pat_d;
      ovl_q  <= ovl_d;
      dout_q <= dout_d;
    end
  end

  // The fill count keeps a zeroed history from matching an all-zero pattern.
  always_comb begin
    hist_d  = hist_q;
    fill_d  = fill_q;
    pat_d   = pat_q;
    ovl_d   = ovl_q;
    dout_d  = 1'b0;
    hit     = 1'b0;
    newHist = {hist_q[PAT_W-2:0], din};
    newFill = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + fill_t'(1);
    if (cfg_load) begin
      pat_d  = cfg_pat;
      ovl_d  = cfg_overlap;
      fill_d = '0;
      hist_d = '0;
    end else if (en) begin
      hit    = (newFill == FILL_FULL) && (newHist == pat_q);
      hist_d = newHist;
      dout_d = hit;
      fill_d = (hit && !ovl_q) ? fill_t'(0) : newFill;
    end
  end

  assign dout = dout_q;

`ifdef SEQ_DET_CNT_EN
  sat_counter #(
    .W(CNT_W)
  ) u_sat_counter (
    .clk  (clk),
    .rst  (rst),
    .inc_i(hit),
    .clr_i(cnt_clr),
    .cnt_o(match_cnt)
  );
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign match_cnt      = '0;
`endif

endmodule

// File: tb/tb_seq_detect_prog.sv
// Scoreboard bench for seq_detect_prog: directed vectors push hand-computed
// expectations, a monitor pops and compares one entry per clock.
module tb_seq_detect_prog;

  logic       clk = 1'b0;
  logic       rstN = 1'b0;
  logic       en = 1'b0;
  logic       din = 1'b0;
  logic       cfgLoad = 1'b0;
  logic [2:0] cfgPat = 3'b000;
  logic       cfgOverlap = 1'b0;
  logic       cntClr = 1'b0;
  logic       dout;
  logic [1:0] matchCnt;

  typedef struct {
    string      name;
    logic       dout;
    logic [1:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   vecCount = 0;
  int   missCount = 0;

  seq_detect_prog #(
    .PAT_W(3),
    .CNT_W(2)
  ) dut (
    .clk        (clk),
    .rst        (rstN),
    .en         (en),
    .din        (din),
    .cfg_load   (cfgLoad),
    .cfg_pat    (cfgPat),
    .cfg_overlap(cfgOverlap),
    .cnt_clr    (cntClr),
    .dout       (dout),
    .match_cnt  (matchCnt)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] cx(input int v);
`ifdef SEQ_DET_CNT_EN
    return v[1:0];
`else
    return (v == 0) ? 2'd0 : 2'd0;
`endif
  endfunction

  // Inputs change on the falling edge; the expected response to the next rising edge is queued.
  task automatic applyStimulus(input string name, input logic r, input logic e, input logic d,
                               input logic ld, input logic [2:0] p, input logic o,
                               input logic clr, input logic expD, input int expC);
    exp_t x;
    @(negedge clk);
    rstN       = r;
    en         = e;
    din        = d;
    cfgLoad    = ld;
    cfgPat     = p;
    cfgOverlap = o;
    cntClr     = clr;
    x.name = name;
    x.dout = expD;
    x.cnt  = cx(expC);
    sb.push_back(x);
  endtask

  task automatic bitIn(input string name, input logic d, input logic expD, input int expC);
    applyStimulus(name, 1'b1, 1'b1, d, 1'b0, 3'b000, 1'b0, 1'b0, expD, expC);
  endtask

  task automatic idleCyc(input string name, input logic d, input int expC);
    applyStimulus(name, 1'b1, 1'b0, d, 1'b0, 3'b111, 1'b1, 1'b0, 1'b0, expC);
  endtask

  task automatic loadCfg(input string name, input logic [2:0] p, input logic o,
                         input logic e, input logic d, input int expC);
    applyStimulus(name, 1'b1, e, d, 1'b1, p, o, 1'b0, 1'b0, expC);
  endtask

  task automatic checkOutput(input exp_t x);
    vecCount++;
    if (dout !== x.dout || matchCnt !== x.cnt) begin
      missCount++;
      $display("[TB] FAIL %s: dout=%b match_cnt=%0d, required dout=%b match_cnt=%0d",
               x.name, dout, matchCnt, x.dout, x.cnt);
    end
  endtask

  // Monitor samples a few time units after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #3;
      if (sb.size() > 0) checkOutput(sb.pop_front());
    end
  end

  initial begin
    applyStimulus("reset", 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 0);
    applyStimulus("reset_hold", 1'b0, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 0);

    // Default pattern 101, overlapping: 1,0,1,0,1 gives two hits.
    bitIn("ovl_b1", 1'b1, 1'b0, 0);
    bitIn("ovl_b2", 1'b0, 1'b0, 0);
    bitIn("ovl_b3", 1'b1, 1'b1, 1);
    bitIn("ovl_b4", 1'b0, 1'b0, 1);
    bitIn("ovl_b5", 1'b1, 1'b1, 2);
    idleCyc("ovl_idle", 1'b1, 2);

    // Non-overlapping 101: same stream gives one hit.
    loadCfg("nov_load", 3'b101, 1'b0, 1'b0, 1'b0, 2);
    bitIn("nov_b1", 1'b1, 1'b0, 2);
    bitIn("nov_b2", 1'b0, 1'b0, 2);
    bitIn("nov_b3", 1'b1, 1'b1, 3);
    bitIn("nov_b4", 1'b0, 1'b0, 3);
    bitIn("nov_b5", 1'b1, 1'b0, 3);
    applyStimulus("clr_idle", 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 0);

    // Gaps in en keep the partial match.
    loadCfg("gap_load", 3'b101, 1'b1, 1'b0, 1'b0, 0);
    bitIn("gap_b1", 1'b1, 1'b0, 0);
    for (int i = 0; i < 4; i++) idleCyc("gap_idle_a", i[0], 0);
    bitIn("gap_b2", 1'b0, 1'b0, 0);
    idleCyc("gap_idle_b0", 1'b0, 0);
    idleCyc("gap_idle_b1", 1'b1, 0);
    bitIn("gap_b3", 1'b1, 1'b1, 1);
    idleCyc("gap_after", 1'b0, 1);

    // Reconfigure to 110; din on the load cycle is discarded.
    loadCfg("rcf_load", 3'b110, 1'b1, 1'b1, 1'b1, 1);
    bitIn("rcf_b1", 1'b1, 1'b0, 1);
    bitIn("rcf_b2", 1'b1, 1'b0, 1);
    bitIn("rcf_b3", 1'b0, 1'b1, 2);
    idleCyc("rcf_idle", 1'b0, 2);

    // Reset mid-stream reverts to 101 and drops the partial match.
    bitIn("rst_b1", 1'b1, 1'b0, 2);
    bitIn("rst_b2", 1'b0, 1'b0, 2);
    applyStimulus("rst_mid", 1'b0, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 0);
    bitIn("rst_b3", 1'b1, 1'b0, 0);
    bitIn("rst_b4", 1'b0, 1'b0, 0);
    bitIn("rst_b5", 1'b1, 1'b1, 1);

    // Saturation at 3, then clear wins over a same-cycle hit.
    bitIn("sat_b1", 1'b0, 1'b0, 1);
    bitIn("sat_b2", 1'b1, 1'b1, 2);
    bitIn("sat_b3", 1'b0, 1'b0, 2);
    bitIn("sat_b4", 1'b1, 1'b1, 3);
    bitIn("sat_b5", 1'b0, 1'b0, 3);
    bitIn("sat_b6", 1'b1, 1'b1, 3);
    bitIn("clr_b1", 1'b0, 1'b0, 3);
    applyStimulus("clr_hit", 1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b1, 1'b1, 0);
    idleCyc("clr_after", 1'b1, 0);

    // Pattern 000 non-overlapping: zeroed history must not match early.
    loadCfg("z_load", 3'b000, 1'b0, 1'b0, 1'b0, 0);
    bitIn("z_b1", 1'b0, 1'b0, 0);
    bitIn("z_b2", 1'b0, 1'b0, 0);
    bitIn("z_b3", 1'b0, 1'b1, 1);
    bitIn("z_b4", 1'b0, 1'b0, 1);
    bitIn("z_b5", 1'b0, 1'b0, 1);
    bitIn("z_b6", 1'b0, 1'b1, 2);

    // Pattern 111 overlapping: back-to-back hits keep dout high.
    loadCfg("o_load", 3'b111, 1'b1, 1'b0, 1'b0, 2);
    bitIn("o_b1", 1'b1, 1'b0, 2);
    bitIn("o_b2", 1'b1, 1'b0, 2);
    bitIn("o_b3", 1'b1, 1'b1, 3);
    bitIn("o_b4", 1'b1, 1'b1, 3);
    idleCyc("o_idle", 1'b1, 3);

    begin : drain
      int waitCyc;
      waitCyc = 0;
      while (sb.size() > 0 && waitCyc < 20) begin
        @(posedge clk);
        waitCyc++;
      end
      @(negedge clk);
      if (sb.size() > 0) begin
        missCount++;
        $display("[TB] FAIL drain: %0d entries pending, required 0", sb.size());
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
